td4_prog_loader: RTL
====================

# td4_prog_loader

Program store and loader sitting directly upstream of the TD4 CPU core. Holds the 16 × 8-bit program the core fetches each cycle on its 4-bit address bus, and lets an external host (tester, microcontroller) stream a new program in byte by byte over a valid/ready handshake. While loading, the core is held in reset; on leaving load mode, the core restarts from address 0 with the new image.

## Interface
Parameters:
- DEPTH, 16: number of instruction words; fixed by the 4-bit TD4 address.
- WIDTH, 8: instruction width (opcode[7:4], immediate[3:0]).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_en  input  1  level; 1 requests load mode, 0 requests run mode.
- wr_valid  input  1  host byte valid.
- wr_data  input  8  host program byte.
- wr_ready  output  1  loader accepts wr_data this cycle.
- wr_count  output  5  bytes accepted in the current load session, 0..16.
- checksum  output  8  mod-256 sum of bytes accepted this session.
- load_done  output  1  1 when 16 bytes accepted (state FULL).
- cpu_rst_n  output  1  active-low reset to the core; 0 unless in RUN.
- addr  input  4  fetch address from the core's program counter.
- instr  output  8  instruction word to the core.

## Operation
- States: RUN, LOAD, FULL. Reset state RUN.
- RUN: instr = mem[addr]; wr_ready = 0; cpu_rst_n = 1. If load_en = 1 → LOAD next cycle; wr_count and checksum cleared to 0 on that transition.
- LOAD: wr_ready = load_en. Transfer occurs when wr_valid & wr_ready: mem[wr_count[3:0]] ← wr_data, wr_count += 1, checksum += wr_data (8-bit wrap). When the transfer makes wr_count = 16 → FULL. If load_en = 0 → RUN (no transfer that cycle).
- FULL: wr_ready = 0; load_done = 1; wr_valid ignored. load_en = 0 → RUN.
- Partial load (load_en dropped early): written entries keep new data, unwritten entries keep previous contents.
- instr = 8'h00 in LOAD and FULL.
- wr_count and checksum hold their values in RUN until the next load session starts (readable after load).
- No pointer wrap: a 17th byte is never accepted.

## Timing
- Reset (rst = 1 at edge): state RUN, all mem words 8'h00, wr_count 0, checksum 8'h00, load_done 0, wr_ready 0, cpu_rst_n 1, instr = mem[addr] = 8'h00.
- instr is combinational from addr and mem: zero-cycle fetch latency, same as the core expects.
- wr_ready is combinational from state and load_en; one byte per cycle max throughput.
- cpu_rst_n is registered from next-state: low from the cycle after load_en is first sampled high, high again from the cycle after load_en is sampled low in LOAD/FULL.
- A byte written at edge N is visible on instr at edge N+1 once back in RUN.
- load_en = 0 and wr_valid = 1 in same LOAD cycle: no write, go to RUN.
- rst during LOAD: reset wins; memory cleared, state RUN.

## Structure
- Shared package td4_pkg: DEPTH/WIDTH constants, state enum (RUN, LOAD, FULL), NOP encoding 8'h00.
- One natural sub-module: td4_prog_ram (16 × 8 register file, sync write, async read, sync clear). Control FSM, counter and checksum stay in the top.

## Test plan
- Reset then addr = 0..15 → instr = 8'h00 for all, cpu_rst_n = 1, wr_ready = 0.
- load_en = 1, stream 16 bytes 8'h30..8'h3F back-to-back → wr_ready high 16 cycles, load_done = 1, wr_count = 16, checksum = 8'h78; load_en = 0 → addr = 5 gives 8'h35, cpu_rst_n = 1 next cycle.
- Full load then 17th wr_valid with 8'hFF → wr_ready = 0, mem[0] unchanged, checksum unchanged.
- After full load, new session writes 3 bytes 8'hB1, 8'hB2, 8'hB3 then load_en = 0 → addr 0..2 = B1..B3, addr 3 = 8'h33, wr_count = 3, checksum = 8'h16.
- Same-cycle load_en fall with wr_valid = 1, wr_data = 8'hAA at wr_count = 4 → no write, mem[4] unchanged, state RUN.
- rst asserted after 7 bytes → all mem = 8'h00, wr_count = 0, checksum = 0, cpu_rst_n = 1, state RUN.

Source files
------------

// File: rtl/td4_prog_loader_pkg.sv
// Shared constants and types for the TD4 program store and loader.
package td4_pkg;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int CW    = 5;

  localparam logic [WIDTH-1:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Host-side byte stream into the program loader (valid/ready handshake).
interface td4_prog_loader_if;

  logic                     wr_valid;
  logic [td4_pkg::WIDTH-1:0] wr_data;
  logic                     wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/td4_prog_loader_ram.sv
// 16 x 8 program register file: synchronous write and clear, asynchronous read.
module td4_prog_ram
  import td4_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Clear has priority so a reset mid-load leaves a blank image.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program store and loader: holds the core's 16-byte program and lets a
// host stream a new image in while the core is held in reset.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_RUN  | core running, fetching from the store; host port closed
//   ST_LOAD | core held in reset, host bytes accepted in address order
//   ST_FULL | all 16 bytes received; further host bytes ignored
module td4_prog_loader
  import td4_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  td4_prog_loader_if.slave    bus,
  output logic [CW-1:0]       wr_count,
  output logic [WIDTH-1:0]    checksum,
  output logic                load_done,
  output logic                cpu_rst_n,
  input  logic [AW-1:0]       addr,
  output logic [WIDTH-1:0]    instr
);

  state_t           state;
  logic             xfer;
  logic [WIDTH-1:0] rdata;

  // Host port is open only while loading and only while the host still wants it.
  always_comb begin
    bus.wr_ready = (state == ST_LOAD) && load_en;
  end

  assign xfer = bus.wr_valid && bus.wr_ready;

  // Fetch path: the core sees NOPs whenever the image is being replaced.
  always_comb begin
    instr = (state == ST_RUN) ? rdata : NOP;
  end

  td4_prog_ram u_ram (
    .clk   (clk),
    .clr   (rst),
    .we    (xfer),
    .waddr (wr_count[AW-1:0]),
    .wdata (bus.wr_data),
    .raddr (addr),
    .rdata (rdata)
  );

  // Control FSM with counter, checksum and registered core-reset / done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wr_count  <= '0;
      checksum  <= '0;
      load_done <= 1'b0;
      cpu_rst_n <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (load_en) begin
            state     <= ST_LOAD;
            wr_count  <= '0;
            checksum  <= '0;
            cpu_rst_n <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!load_en) begin
            state     <= ST_RUN;
            cpu_rst_n <= 1'b1;
          end else if (xfer) begin
            wr_count <= wr_count + 5'd1;
            checksum <= checksum + bus.wr_data;
            // Last slot filled: stop accepting rather than wrapping to slot 0.
            if (wr_count == 5'd15) begin
              state     <= ST_FULL;
              load_done <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (!load_en) begin
            state     <= ST_RUN;
            load_done <= 1'b0;
            cpu_rst_n <= 1'b1;
          end
        end
        default: begin
          state     <= ST_RUN;
          load_done <= 1'b0;
          cpu_rst_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
